sram_stream_reader: RTL and testbench

SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

---
 rtl/sram_stream_reader_pkg.sv | 19 +
 rtl/sram_rd_fifo.sv | 73 +++++++
 rtl/sram_stream_reader.sv | 155 +++++++++++++++
 tb/tb_sram_stream_reader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_reader_pkg.sv
// Shared constants and FSM state type for the SRAM stream reader.
package sram_stream_reader_pkg;

  localparam int SRAM_DEPTH = 8192;
  localparam int SRAM_AW    = 13;
  localparam int SRAM_DW    = 128;
  localparam int CNT_W      = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [SRAM_AW-1:0] addr_inc(input logic [SRAM_AW-1:0] addr);
    return addr + {{(SRAM_AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous FIFO with flop storage, head word read straight from the storage flops,
// and an occupancy count.
module sram_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 129
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && (count_q != CNT_FULL);
    do_pop   = pop && (count_q != CNT_ZERO);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != CNT_ZERO);
  assign count      = count_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Streams a burst of words out of an 8192x128 SRAM read port into a small output buffer.
// Define SRAM_READER_WRAP_EN to wrap addresses 8191->0 instead of stopping with err.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [12:0]        start_addr,
  input  logic [13:0]        word_count,
  output logic [12:0]        ReadAddress,
  input  logic [127:0]       ReadBus,
  output logic [127:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]        DEPTH_W  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d, rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]     remain_q, remain_d;
  logic                 inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic                 err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic                 room_s, overflow_s, last_xfer_s;
  logic [CW:0]          occ_s;
  logic [CW-1:0]        fifo_count;
  logic [SRAM_DW:0]     head_data;
  logic                 head_valid;

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SRAM_DW + 1)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (inflight_q),
    .push_data  ({inflight_last_q, ReadBus}),
    .pop        (out_ready),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

`ifdef SRAM_READER_WRAP_EN
  assign overflow_s = 1'b0;
`else
  localparam logic [SRAM_AW-1:0] ADDR_MAX = 13'h1FFF;
  // Stop before stepping past the top of the SRAM while words are still owed.
  assign overflow_s = (addr_q == ADDR_MAX) && (remain_q > CNT_ONE);
`endif

  // Credit check counts reads already in flight so the buffer can never overflow.
  assign occ_s       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign room_s      = (occ_s < DEPTH_W);
  assign last_xfer_s = head_valid && out_ready && head_data[SRAM_DW];

  // FSM next-state, issue control and status flags.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    rd_addr_d       = rd_addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    err_d           = err_q;
    done_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (word_count != CNT_ZERO) begin
            addr_d   = start_addr;
            remain_d = word_count;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (room_s) begin
          rd_addr_d  = addr_q;
          inflight_d = 1'b1;
          addr_d     = addr_inc(addr_q);
          remain_d   = remain_q - CNT_ONE;
          if ((remain_q == CNT_ONE) || overflow_s) begin
            inflight_last_d = 1'b1;
            state_d         = DRAIN;
            err_d           = err_q | overflow_s;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (last_xfer_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      addr_q          <= {SRAM_AW{1'b0}};
      remain_q        <= CNT_ZERO;
      rd_addr_q       <= {SRAM_AW{1'b0}};
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      rd_addr_q       <= rd_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      err_q           <= err_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
    end
  end

  assign ReadAddress = rd_addr_q;
  assign out_data    = head_data[SRAM_DW-1:0];
  assign out_valid   = head_valid;
  assign out_last    = head_valid && head_data[SRAM_DW];
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader: SRAM model returns word[i]=i.
module tb_sram_stream_reader;

  localparam int FIFO_DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [12:0]  start_addr = 13'd0;
  logic [13:0]  word_count = 14'd0;
  logic [12:0]  ReadAddress;
  logic [127:0] ReadBus;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy, done, err;

  sram_stream_reader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .start_addr  (start_addr),
    .word_count  (word_count),
    .ReadAddress (ReadAddress),
    .ReadBus     (ReadBus),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  assign ReadBus = {115'd0, ReadAddress};

  logic [128:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int issue_cnt = 0;
  int busy_cnt = 0;
  int valid_cnt = 0;
  bit zero_mode = 1'b0;
  bit prev_last_xfer = 1'b0;
  logic [12:0] prev_addr = 13'd0;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_word(input logic [12:0] addr, input bit last);
    exp_q.push_back({last, 115'd0, addr});
  endtask

  // Monitor: pops the scoreboard on every transfer and tracks issue/done activity.
  always @(negedge clock) begin
    logic [128:0] e;
    if (busy) busy_cnt++;
    if (out_valid) valid_cnt++;
    if (ReadAddress != prev_addr) issue_cnt++;
    prev_addr = ReadAddress;
    if (done) begin
      done_cnt++;
      if (!zero_mode) check("done_after_last", {128'd0, prev_last_xfer}, 129'd1);
    end
    prev_last_xfer = 1'b0;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {out_last, out_data}, 129'h0 - 129'd1);
      end else begin
        e = exp_q.pop_front();
        check("word", {out_last, out_data}, e);
      end
      prev_last_xfer = out_last;
    end
  end

  task automatic start_burst(input logic [12:0] addr, input logic [13:0] cnt);
    @(posedge clock); #1;
    start_addr = addr;
    word_count = cnt;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    int base = done_cnt;
    int k = 0;
    while (done_cnt == base && k < bound) begin
      @(posedge clock); #2;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      k++;
    end
    check("done_seen", {128'd0, done_cnt != base}, 129'd1);
    check("all_words_delivered", 129'(exp_q.size()), 129'd0);
    repeat (3) @(posedge clock);
    #2;
    check("single_done_pulse", 129'(done_cnt - base), 129'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_iss, base_done, base_busy, base_valid, exp_iss;
    logic exp_err;

    repeat (3) @(posedge clock);
    #1;
    check("rst_addr",  {116'd0, ReadAddress}, 129'd0);
    check("rst_flags", {123'd0, out_valid, out_last, busy, done, err, 1'b0}, 129'd0);
    reset_n = 1'b1;

    // Basic burst 10..14 with consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(13'(10 + i), i == 4);
    start_burst(13'd10, 14'd5);
    wait_done(100, 1'b0);
    check("busy_after_done", {128'd0, busy}, 129'd0);
    check("err_basic", {128'd0, err}, 129'd0);

    // Back-pressure: only FIFO_DEPTH reads may be outstanding.
    out_ready = 1'b0;
    base_iss = issue_cnt;
    for (int i = 0; i < 8; i++) push_word(13'(200 + i), i == 7);
    start_burst(13'd200, 14'd8);
    repeat (20) @(posedge clock);
    #2;
    check("stall_issues", 129'(issue_cnt - base_iss), 129'(FIFO_DEPTH));
    check("stall_head", {out_last, out_data}, 129'd200);
    check("stall_busy", {128'd0, busy}, 129'd1);
    out_ready = 1'b1;
    wait_done(200, 1'b0);

    // Top-of-memory boundary.
    base_iss = issue_cnt;
`ifdef SRAM_READER_WRAP_EN
    push_word(13'd8190, 1'b0); push_word(13'd8191, 1'b0);
    push_word(13'd0, 1'b0);    push_word(13'd1, 1'b1);
    exp_err = 1'b0; exp_iss = 4;
`else
    push_word(13'd8190, 1'b0); push_word(13'd8191, 1'b1);
    exp_err = 1'b1; exp_iss = 2;
`endif
    start_burst(13'd8190, 14'd4);
    wait_done(100, 1'b0);
    check("boundary_err", {128'd0, err}, {128'd0, exp_err});
    check("boundary_issues", 129'(issue_cnt - base_iss), 129'(exp_iss));

    // Zero-length request.
    zero_mode  = 1'b1;
    base_done  = done_cnt;
    base_busy  = busy_cnt;
    base_valid = valid_cnt;
    start_burst(13'd5, 14'd0);
    repeat (5) @(posedge clock);
    #2;
    check("zero_done", 129'(done_cnt - base_done), 129'd1);
    check("zero_busy", 129'(busy_cnt - base_busy), 129'd0);
    check("zero_valid", 129'(valid_cnt - base_valid), 129'd0);
    check("err_cleared", {128'd0, err}, 129'd0);
    zero_mode = 1'b0;

    // Reset mid-burst, then start on the first cycle after release.
    out_ready = 1'b0;
    start_burst(13'd300, 14'd6);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_addr",  {116'd0, ReadAddress}, 129'd0);
    check("midrst_flags", {124'd0, out_valid, out_last, busy, done, err}, 129'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    base_iss = issue_cnt;
    push_word(13'd100, 1'b0); push_word(13'd101, 1'b1);
    start_addr = 13'd100;
    word_count = 14'd2;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(100, 1'b0);
    check("post_rst_issues", 129'(issue_cnt - base_iss), 129'd2);

    // Full-memory burst under random back-pressure.
    for (int i = 0; i < 8192; i++) push_word(13'(i), i == 8191);
    start_burst(13'd0, 14'd8192);
    wait_done(40000, 1'b1);
    check("err_full", {128'd0, err}, 129'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
